// File: rtl/kamus_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : kamus_pkg
//  Purpose  : Shared types for the kamus memory-port arbiter: arbiter state
//             and transaction-owner encodings.
//  Revision : 1.0  initial release
// ============================================================================
package kamus_pkg;

    // Arbiter phase: idle (may issue), holding an un-granted request,
    // waiting for the response of a granted request.
    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_HOLD = 2'd1,
        ARB_RSP  = 2'd2
    } arb_state_e;

    // Which requester owns the memory port.
    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_LSU = 1'b1
    } arb_owner_e;

endpackage : kamus_pkg
`default_nettype wire

// File: rtl/kamus_arb_pick.sv
`default_nettype none
// ============================================================================
//  Module   : kamus_arb_pick
//  Purpose  : Combinational tie-break between the fetch and LSU requesters.
//             Build option KAMUS_ARB_RR_EN: ties go to the requester that was
//             not granted last. Without it the LSU always wins a tie.
//  Revision : 1.0  initial release
// ============================================================================
module kamus_arb_pick
    import kamus_pkg::*;
(
    input  logic if_req_i,
    input  logic lsu_req_i,
    input  logic last_grant_i,
    output logic owner_o
);

    // Choose the owner; with no request the last grant is simply echoed
    // since the result is not used by the arbiter in that case.
    always_comb begin
        owner_o = last_grant_i;
        if (if_req_i && lsu_req_i) begin
`ifdef KAMUS_ARB_RR_EN
            owner_o = (last_grant_i == OWN_LSU) ? OWN_IF : OWN_LSU;
`else
            owner_o = OWN_LSU;
`endif
        end else if (lsu_req_i) begin
            owner_o = OWN_LSU;
        end else if (if_req_i) begin
            owner_o = OWN_IF;
        end
    end

endmodule : kamus_arb_pick
`default_nettype wire

// File: rtl/kamus_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : kamus_mem_arbiter
//  Purpose  : Shares one memory port between instruction fetch and the LSU,
//             one transaction outstanding at a time. Request payload is
//             forwarded combinationally from the owning requester.
//             Build option KAMUS_ARB_RR_EN selects round-robin tie-break
//             (adds a last-grant register); default is fixed LSU priority.
//  Revision : 1.0  initial release
// ============================================================================
module kamus_mem_arbiter
    import kamus_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
)(
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  if_req_i,
    input  logic [ADDR_W-1:0]     if_addr_i,
    output logic                  if_gnt_o,
    output logic                  if_rvalid_o,
    output logic [DATA_W-1:0]     if_rdata_o,

    input  logic                  lsu_req_i,
    input  logic                  lsu_we_i,
    input  logic [DATA_W/8-1:0]   lsu_be_i,
    input  logic [ADDR_W-1:0]     lsu_addr_i,
    input  logic [DATA_W-1:0]     lsu_wdata_i,
    output logic                  lsu_gnt_o,
    output logic                  lsu_rvalid_o,
    output logic [DATA_W-1:0]     lsu_rdata_o,

    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [DATA_W/8-1:0]   mem_be_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic [DATA_W-1:0]     mem_wdata_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_W-1:0]     mem_rdata_i,

    output logic                  spurious_o
);

    arb_state_e state_q, state_d;
    arb_owner_e owner_q, owner_d;
    logic       spurious_q, spurious_d;

    logic       w_any_req;
    logic       w_pick;
    logic       w_last_grant;
    arb_owner_e w_cur_owner;
    logic       w_req_int;
    logic       w_accept;
    logic       w_rsp;

    assign w_any_req = if_req_i | lsu_req_i;

    kamus_arb_pick u_pick (
        .if_req_i     (if_req_i),
        .lsu_req_i    (lsu_req_i),
        .last_grant_i (w_last_grant),
        .owner_o      (w_pick)
    );

`ifdef KAMUS_ARB_RR_EN
    arb_owner_e last_q, last_d;

    // Remember who received the most recent grant.
    always_comb begin
        last_d = last_q;
        if (w_accept) begin
            last_d = w_cur_owner;
        end
    end

    // Last-grant register; starts as IF so the first tie goes to the LSU.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_q <= OWN_IF;
        end else begin
            last_q <= last_d;
        end
    end

    assign w_last_grant = last_q;
`else
    assign w_last_grant = OWN_IF;
`endif

    // Next-state logic; in IDLE the owner comes straight from the picker.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        w_cur_owner = owner_q;
        w_req_int   = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                w_cur_owner = arb_owner_e'(w_pick);
                if (w_any_req) begin
                    w_req_int = 1'b1;
                    owner_d   = w_cur_owner;
                    state_d   = mem_gnt_i ? ARB_RSP : ARB_HOLD;
                end
            end
            ARB_HOLD: begin
                w_req_int = 1'b1;
                if (mem_gnt_i) begin
                    state_d = ARB_RSP;
                end
            end
            ARB_RSP: begin
                if (mem_rvalid_i) begin
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // Any response while nothing is outstanding latches the sticky flag.
    always_comb begin
        spurious_d = spurious_q;
        if (mem_rvalid_i && (state_q != ARB_RSP)) begin
            spurious_d = 1'b1;
        end
    end

    // State, owner and sticky-flag registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ARB_IDLE;
            owner_q    <= OWN_LSU;
            spurious_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            spurious_q <= spurious_d;
        end
    end

    // Reset gates the handshake outputs combinationally so they drop at once.
    assign mem_req_o = w_req_int & ~rst_i;
    assign w_accept  = mem_req_o & mem_gnt_i;
    assign w_rsp     = (state_q == ARB_RSP) & mem_rvalid_i & ~rst_i;

    assign mem_we_o    = (w_cur_owner == OWN_LSU) ? lsu_we_i    : 1'b0;
    assign mem_be_o    = (w_cur_owner == OWN_LSU) ? lsu_be_i    : '1;
    assign mem_addr_o  = (w_cur_owner == OWN_LSU) ? lsu_addr_i  : if_addr_i;
    assign mem_wdata_o = (w_cur_owner == OWN_LSU) ? lsu_wdata_i : '0;

    assign if_gnt_o     = w_accept & (w_cur_owner == OWN_IF);
    assign lsu_gnt_o    = w_accept & (w_cur_owner == OWN_LSU);
    assign if_rvalid_o  = w_rsp & (owner_q == OWN_IF);
    assign lsu_rvalid_o = w_rsp & (owner_q == OWN_LSU);
    assign if_rdata_o   = mem_rdata_i;
    assign lsu_rdata_o  = mem_rdata_i;

    assign spurious_o = spurious_q;

endmodule : kamus_mem_arbiter
`default_nettype wire

// File: tb/tb_kamus_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_kamus_mem_arbiter
//  Purpose  : Self-checking bench for kamus_mem_arbiter: directed scenarios
//             plus randomized traffic checked against a transaction-level
//             reference model. Honours KAMUS_ARB_RR_EN when defined.
//  Revision : 1.0  initial release
// ============================================================================
module tb_kamus_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam logic C_IF  = 1'b0;
    localparam logic C_LSU = 1'b1;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt, if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          lsu_req, lsu_we;
    logic [3:0]    lsu_be;
    logic [AW-1:0] lsu_addr;
    logic [DW-1:0] lsu_wdata;
    logic          lsu_gnt, lsu_rvalid;
    logic [DW-1:0] lsu_rdata;
    logic          mem_req, mem_we;
    logic [3:0]    mem_be;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_gnt, mem_rvalid;
    logic [DW-1:0] mem_rdata;
    logic          spurious;

    int checks = 0;
    int errors = 0;

    // Transaction-level reference model
    bit   m_busy;      // a transaction has been issued and not yet answered
    bit   m_granted;   // the issued transaction has been accepted by memory
    logic m_owner;
    logic m_last;      // who was granted most recently
    bit   m_spur;

    // Expectations of the current cycle (also steer the requesters)
    logic e_if_gnt, e_lsu_gnt;

    logic q_order [$];

    kamus_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .if_req_i     (if_req),
        .if_addr_i    (if_addr),
        .if_gnt_o     (if_gnt),
        .if_rvalid_o  (if_rvalid),
        .if_rdata_o   (if_rdata),
        .lsu_req_i    (lsu_req),
        .lsu_we_i     (lsu_we),
        .lsu_be_i     (lsu_be),
        .lsu_addr_i   (lsu_addr),
        .lsu_wdata_i  (lsu_wdata),
        .lsu_gnt_o    (lsu_gnt),
        .lsu_rvalid_o (lsu_rvalid),
        .lsu_rdata_o  (lsu_rdata),
        .mem_req_o    (mem_req),
        .mem_we_o     (mem_we),
        .mem_be_o     (mem_be),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_gnt_i    (mem_gnt),
        .mem_rvalid_i (mem_rvalid),
        .mem_rdata_i  (mem_rdata),
        .spurious_o   (spurious)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Who would win the port if it were free right now.
    function automatic logic arb_choice(input logic ir, input logic lr, input logic last);
        logic r;
        if (ir && lr) begin
`ifdef KAMUS_ARB_RR_EN
            r = ~last;
`else
            r = C_LSU;
            if (last === 1'bx) r = C_LSU;
`endif
        end else begin
            r = lr ? C_LSU : C_IF;
        end
        return r;
    endfunction

    // One clock: check at the falling edge, advance the model at the rising edge.
    task automatic cycle();
        logic own, e_req, e_ifv, e_lsv;
        @(negedge clk);
        own   = m_busy ? m_owner : arb_choice(if_req, lsu_req, m_last);
        e_req = !rst && ((!m_busy && (if_req || lsu_req)) || (m_busy && !m_granted));
        e_if_gnt  = e_req && mem_gnt && (own == C_IF);
        e_lsu_gnt = e_req && mem_gnt && (own == C_LSU);
        e_ifv = !rst && m_busy && m_granted && mem_rvalid && (m_owner == C_IF);
        e_lsv = !rst && m_busy && m_granted && mem_rvalid && (m_owner == C_LSU);
        chk("mem_req", mem_req, e_req);
        chk("if_gnt", if_gnt, e_if_gnt);
        chk("lsu_gnt", lsu_gnt, e_lsu_gnt);
        chk("if_rvalid", if_rvalid, e_ifv);
        chk("lsu_rvalid", lsu_rvalid, e_lsv);
        chk("if_rdata", if_rdata, mem_rdata);
        chk("lsu_rdata", lsu_rdata, mem_rdata);
        chk("spurious", spurious, rst ? 1'b0 : m_spur);
        if (e_req) begin
            chk("mem_addr", mem_addr, (own == C_LSU) ? lsu_addr : if_addr);
            chk("mem_we", mem_we, (own == C_LSU) ? lsu_we : 1'b0);
            chk("mem_be", mem_be, (own == C_LSU) ? lsu_be : 4'hF);
            if (own == C_LSU) chk("mem_wdata", mem_wdata, lsu_wdata);
        end
        @(posedge clk);
        if (rst) begin
            m_busy = 0; m_granted = 0; m_owner = C_LSU; m_last = C_IF; m_spur = 0;
        end else begin
            if (mem_rvalid && !(m_busy && m_granted)) m_spur = 1;
            if (!m_busy) begin
                if (if_req || lsu_req) begin
                    m_busy = 1;
                    m_owner = own;
                    m_granted = mem_gnt;
                    if (mem_gnt) m_last = own;
                end
            end else if (!m_granted) begin
                if (mem_gnt) begin
                    m_granted = 1;
                    m_last = m_owner;
                end
            end else if (mem_rvalid) begin
                m_busy = 0;
                m_granted = 0;
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        if_req = 0; if_addr = '0;
        lsu_req = 0; lsu_we = 0; lsu_be = '0; lsu_addr = '0; lsu_wdata = '0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        cycle();
        cycle();
        rst = 0;
    endtask

    initial begin
        m_busy = 0; m_granted = 0; m_owner = C_LSU; m_last = C_IF; m_spur = 0;
        e_if_gnt = 0; e_lsu_gnt = 0;
        idle_inputs();
        rst = 1;
        #2;
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_spurious", spurious, 1'b0);
        cycle();
        cycle();
        rst = 0;

        // Single fetch, granted immediately, data two cycles later
        if_req = 1; if_addr = 32'h100; mem_gnt = 1;
        #1;
        chk("f_if_gnt", if_gnt, 1'b1);
        chk("f_addr", mem_addr, 32'h100);
        chk("f_we", mem_we, 1'b0);
        chk("f_be", mem_be, 4'hF);
        cycle();
        if_req = 0; mem_gnt = 0;
        cycle();
        mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
        #1;
        chk("f_rvalid", if_rvalid, 1'b1);
        chk("f_rdata", if_rdata, 32'hDEADBEEF);
        chk("f_lsu_rvalid", lsu_rvalid, 1'b0);
        cycle();
        mem_rvalid = 0;
        cycle();

        // Both requesting: LSU store first, fetch after response plus bubble
        if_req = 1; if_addr = 32'h200;
        lsu_req = 1; lsu_we = 1; lsu_be = 4'h3; lsu_addr = 32'h300; lsu_wdata = 32'h1234;
        mem_gnt = 1;
        #1;
        chk("t_lsu_gnt", lsu_gnt, 1'b1);
        chk("t_if_gnt", if_gnt, 1'b0);
        chk("t_we", mem_we, 1'b1);
        chk("t_be", mem_be, 4'h3);
        chk("t_wdata", mem_wdata, 32'h1234);
        cycle();
        lsu_req = 0; lsu_we = 0;
        cycle();
        mem_rvalid = 1; mem_rdata = 32'h0;
        #1;
        chk("t_bubble_req", mem_req, 1'b0);
        chk("t_lsu_rvalid", lsu_rvalid, 1'b1);
        cycle();
        mem_rvalid = 0;
        #1;
        chk("t_if_after", if_gnt, 1'b1);
        chk("t_if_addr", mem_addr, 32'h200);
        cycle();
        if_req = 0; mem_gnt = 0;
        mem_rvalid = 1;
        cycle();
        mem_rvalid = 0;
        cycle();

        // Memory stalls an IF request; LSU arrives meanwhile and waits
        if_req = 1; if_addr = 32'h500; mem_gnt = 0;
        cycle();
        lsu_req = 1; lsu_addr = 32'h600; lsu_be = 4'hF; lsu_wdata = 32'h55;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("h_addr", mem_addr, 32'h500);
            chk("h_req", mem_req, 1'b1);
            cycle();
        end
        mem_gnt = 1;
        #1;
        chk("h_if_gnt", if_gnt, 1'b1);
        cycle();
        if_req = 0; mem_gnt = 0;
        mem_rvalid = 1;
        cycle();
        mem_rvalid = 0; mem_gnt = 1;
        #1;
        chk("h_lsu_next", lsu_gnt, 1'b1);
        chk("h_lsu_addr", mem_addr, 32'h600);
        cycle();
        lsu_req = 0; mem_gnt = 0; mem_rvalid = 1;
        cycle();
        mem_rvalid = 0;

        // Continuous contention: record four grants
        do_reset();
        if_req = 1; if_addr = 32'h80;
        lsu_req = 1; lsu_we = 0; lsu_be = 4'hF; lsu_addr = 32'h40;
        for (int i = 0; i < 40 && q_order.size() < 4; i++) begin
            mem_gnt = 1;
            mem_rvalid = m_busy && m_granted;
            #1;
            if (if_gnt)  q_order.push_back(C_IF);
            if (lsu_gnt) q_order.push_back(C_LSU);
            cycle();
        end
        chk("rr_count", q_order.size(), 4);
        if (q_order.size() >= 4) begin
            logic [3:0] got;
            for (int i = 0; i < 4; i++) got[3-i] = q_order[i];
`ifdef KAMUS_ARB_RR_EN
            chk("grant_order", got, 4'b1010);
`else
            chk("grant_order", got, 4'b1111);
`endif
        end
        idle_inputs();
        mem_rvalid = m_busy && m_granted;
        cycle();
        mem_rvalid = 0;

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (!if_req || e_if_gnt) begin
                if_req = ($urandom % 2) == 1;
                if_addr = $urandom;
            end
            if (!lsu_req || e_lsu_gnt) begin
                lsu_req = ($urandom % 2) == 1;
                lsu_we = ($urandom % 2) == 1;
                lsu_be = 4'($urandom);
                lsu_addr = $urandom;
                lsu_wdata = $urandom;
            end
            mem_gnt = ($urandom % 3) != 0;
            mem_rvalid = (m_busy && m_granted) ? (($urandom % 2) == 1) : 1'b0;
            mem_rdata = $urandom;
            cycle();
        end
        idle_inputs();
        for (int i = 0; i < 10 && m_busy; i++) begin
            mem_gnt = 1;
            mem_rvalid = m_busy && m_granted;
            cycle();
        end
        mem_gnt = 0; mem_rvalid = 0;
        chk("rand_drained", m_busy, 1'b0);

        // Response with nothing outstanding
        cycle();
        mem_rvalid = 1; mem_rdata = 32'hABCD;
        #1;
        chk("s_if_rvalid", if_rvalid, 1'b0);
        chk("s_lsu_rvalid", lsu_rvalid, 1'b0);
        cycle();
        mem_rvalid = 0;
        #1;
        chk("s_flag", spurious, 1'b1);
        cycle();
        cycle();

        // Reset while waiting for a response
        if_req = 1; if_addr = 32'h700; mem_gnt = 1;
        cycle();
        mem_gnt = 0;
        cycle();
        rst = 1;
        #1;
        chk("r_req", mem_req, 1'b0);
        chk("r_if_gnt", if_gnt, 1'b0);
        chk("r_spur", spurious, 1'b0);
        cycle();
        rst = 0; if_req = 0;
        mem_rvalid = 1;
        cycle();
        mem_rvalid = 0;
        #1;
        chk("r_late_spur", spurious, 1'b1);
        if_req = 1; if_addr = 32'h900; mem_gnt = 1;
        #1;
        chk("r_new_gnt", if_gnt, 1'b1);
        chk("r_new_addr", mem_addr, 32'h900);
        cycle();
        if_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h77;
        cycle();
        mem_rvalid = 0;
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_kamus_mem_arbiter
`default_nettype wire
